// File: rtl/alu4_operand_sequencer_pkg.sv
// Shared definitions for the 4-bit ALU operand sequencer: FSM states,
// ALU opcode encodings and the bit positions of the captured flag vector.
package alu4_operand_sequencer_pkg;

  typedef enum logic [2:0] {
    S_OP     = 3'd0,
    S_A      = 3'd1,
    S_B      = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4
  } seq_state_e;

  localparam logic [3:0] OP_LSL   = 4'd0;
  localparam logic [3:0] OP_LSR   = 4'd1;
  localparam logic [3:0] OP_ASR   = 4'd2;
  localparam logic [3:0] OP_ROR   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_INC   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_DEC   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_OR    = 4'd10;
  localparam logic [3:0] OP_NOT   = 4'd11;
  localparam logic [3:0] OP_NEG   = 4'd12;
  localparam logic [3:0] OP_PASSA = 4'd13;
  localparam logic [3:0] OP_EQ    = 4'd14;
  localparam logic [3:0] OP_SLT   = 4'd15;

  // Positions inside the 3-bit {V,C,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;

  // Settle counter width; enough for the 1..15 cycle settle range.
  localparam int SETTLE_W = 4;

  // Pull the {V,C} pair out of a captured flag vector for the sticky register.
  function automatic logic [1:0] flags_to_cv(input logic [2:0] flags);
    return {flags[FLAG_V], flags[FLAG_C]};
  endfunction

endpackage

// File: rtl/alu4_settle_timer.sv
// Down-counter that holds the ALU operands for a fixed number of cycles.
// Loaded once per transaction; counts down while enabled and parks at zero.
module alu4_settle_timer
  import alu4_operand_sequencer_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load wins over a decrement, and the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu4_operand_sequencer.sv
// Wrapper stage around the external combinational 4-bit ALU. Gathers
// opcode/A/B nibbles over a valid/ready input, holds them stable on the
// ALU for ALU_SETTLE cycles, captures result and flags, and offers them on
// a valid/ready output. Also keeps sticky {V,C} and a completed-op counter.
module alu4_operand_sequencer
  import alu4_operand_sequencer_pkg::*;
#(
  parameter int ALU_SETTLE = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_out,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [3:0]       res_data,
  output logic [2:0]       res_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       sticky_cv,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  // The timer counts down to zero, so a settle of N cycles loads N-1.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(ALU_SETTLE - 1);

  seq_state_e       state_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [3:0]       alu_opcode_q;
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [3:0]       res_data_q;
  logic [2:0]       res_flags_q;
  logic [1:0]       sticky_q;
  logic [1:0]       sticky_d;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;

  logic in_fire;
  logic res_fire;
  logic settle_load;
  logic settle_dec;
  logic settle_zero;

  // Abort suppresses both handshakes so a dropped transaction leaves no trace.
  assign in_fire     = in_valid & in_ready_q & ~abort;
  assign res_fire    = res_valid_q & res_ready & ~abort;
  assign settle_load = in_fire & (state_q == S_B);
  assign settle_dec  = (state_q == S_EXEC);

  alu4_settle_timer #(
    .W(SETTLE_W)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (settle_load),
    .load_val_i(SETTLE_LOAD),
    .dec_i     (settle_dec),
    .zero_o    (settle_zero)
  );

  // Counter and sticky flags only move on a real result handshake; clearing the sticky flags beats a coincident update.
  always_comb begin
    op_count_d = op_count_q;
    sticky_d   = sticky_q;
    if (res_fire) begin
      op_count_d = op_count_q + CNT_W'(1);
      sticky_d   = sticky_q | flags_to_cv(res_flags_q);
    end
    if (clr_sticky) begin
      sticky_d = '0;
    end
  end

  // Sequencer FSM with all outputs registered; in_ready is set alongside each state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OP;
      in_ready_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_data_q   <= '0;
      res_flags_q  <= '0;
      sticky_q     <= '0;
      op_count_q   <= '0;
    end else begin
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
      if (abort) begin
        state_q     <= S_OP;
        in_ready_q  <= 1'b1;
        res_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_OP: begin
            if (in_fire) begin
              alu_opcode_q <= in_data;
              state_q      <= S_A;
            end
          end
          S_A: begin
            if (in_fire) begin
              alu_a_q <= in_data;
              state_q <= S_B;
            end
          end
          S_B: begin
            if (in_fire) begin
              alu_b_q    <= in_data;
              state_q    <= S_EXEC;
              in_ready_q <= 1'b0;
            end
          end
          S_EXEC: begin
            if (settle_zero) begin
              res_data_q  <= alu_out;
              res_flags_q <= {alu_v, alu_c, alu_z};
              res_valid_q <= 1'b1;
              state_q     <= S_RESULT;
            end
          end
          S_RESULT: begin
            if (res_fire) begin
              res_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_OP;
            end
          end
          default: begin
            state_q     <= S_OP;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign res_valid  = res_valid_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign sticky_cv  = sticky_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu4_operand_sequencer.sv
// Self-checking bench for alu4_operand_sequencer. A small behavioural ALU
// sits on the alu_* ports; expected results are queued when a transaction
// is driven and popped when res_valid appears.
module tb_alu4_operand_sequencer;
  import alu4_operand_sequencer_pkg::*;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       inData;
  logic             inValid;
  logic             inReady;
  logic             abortIn;
  logic [3:0]       aluOpcode;
  logic [3:0]       aluA;
  logic [3:0]       aluB;
  logic [3:0]       aluOut;
  logic             aluZ;
  logic             aluC;
  logic             aluV;
  logic [3:0]       resData;
  logic [2:0]       resFlags;
  logic             resValid;
  logic             resReady;
  logic [1:0]       stickyCv;
  logic             clrSticky;
  logic [CNT_W-1:0] opCount;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] flags;
  } result_t;

  result_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  alu4_operand_sequencer #(
    .ALU_SETTLE(1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .abort     (abortIn),
    .alu_opcode(aluOpcode),
    .alu_a     (aluA),
    .alu_b     (aluB),
    .alu_out   (aluOut),
    .alu_z     (aluZ),
    .alu_c     (aluC),
    .alu_v     (aluV),
    .res_data  (resData),
    .res_flags (resFlags),
    .res_valid (resValid),
    .res_ready (resReady),
    .sticky_cv (stickyCv),
    .clr_sticky(clrSticky),
    .op_count  (opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational ALU.
  always_comb begin
    logic [4:0] wide;
    wide   = '0;
    aluOut = aluA;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (aluOpcode)
      OP_LSL: begin
        wide   = {1'b0, aluB} << aluA[1:0];
        aluOut = wide[3:0];
        aluC   = wide[4];
      end
      OP_ADD: begin
        wide   = {1'b0, aluA} + {1'b0, aluB};
        aluOut = wide[3:0];
        aluC   = wide[4];
        aluV   = (aluA[3] == aluB[3]) && (wide[3] != aluA[3]);
      end
      OP_SUB: begin
        wide   = {1'b0, aluA} - {1'b0, aluB};
        aluOut = wide[3:0];
        aluC   = wide[4];
        aluV   = (aluA[3] != aluB[3]) && (wide[3] != aluA[3]);
      end
      OP_AND: aluOut = aluA & aluB;
      OP_XOR: aluOut = aluA ^ aluB;
      OP_OR:  aluOut = aluA | aluB;
      default: aluOut = aluA;
    endcase
    aluZ = (aluOut == 4'd0);
  end

  // Step to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive opcode, A, B back-to-back and queue the expected result.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] expData, input logic [2:0] expFlags);
    logic [3:0] nib [3];
    result_t e;
    nib = '{op, a, b};
    for (int i = 0; i < 3; i++) begin
      inData  = nib[i];
      inValid = 1'b1;
      checkOutput("in_ready_before_accept", inReady, 1);
      tick();
    end
    inValid = 1'b0;
    e.data  = expData;
    e.flags = expFlags;
    expQ.push_back(e);
    checkOutput("in_ready_in_exec", inReady, 0);
  endtask

  // Wait (bounded) for res_valid, check latency from the B-accept cycle, then compare against the scoreboard.
  task automatic waitResult(input int expLatency);
    int lat;
    bit got;
    result_t e;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 32 && !got; k++) begin
      tick();
      lat++;
      if (resValid) got = 1'b1;
    end
    if (!got) begin
      checkOutput("res_valid_timeout", 0, 1);
    end else begin
      checkOutput("latency", lat, expLatency);
      if (expQ.size() == 0) begin
        checkOutput("scoreboard_empty", 0, 1);
      end else begin
        e = expQ.pop_front();
        checkOutput("res_data", resData, e.data);
        checkOutput("res_flags", resFlags, e.flags);
      end
    end
  endtask

  task automatic handshake;
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    rst       = 1'b1;
    inData    = '0;
    inValid   = 1'b0;
    abortIn   = 1'b0;
    resReady  = 1'b0;
    clrSticky = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_res_valid", resValid, 0);
    checkOutput("rst_op_count", opCount, 0);
    checkOutput("rst_sticky", stickyCv, 0);
    checkOutput("rst_alu_opcode", aluOpcode, 0);
    checkOutput("rst_res_data", resData, 0);
    rst = 1'b0;
    tick();

    // Add 7+9: result 0, C=1, Z=1
    applyStimulus(OP_ADD, 4'd7, 4'd9, 4'd0, 3'b011);
    waitResult(2);
    handshake();
    checkOutput("add_res_valid_cleared", resValid, 0);
    checkOutput("add_op_count", opCount, 1);
    checkOutput("add_sticky", stickyCv, 2'b01);
    checkOutput("add_in_ready_next", inReady, 1);

    // Sub 3-5 with consumer stalling for 5 cycles
    applyStimulus(OP_SUB, 4'd3, 4'd5, 4'b1110, 3'b010);
    waitResult(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("sub_hold_valid", resValid, 1);
      checkOutput("sub_hold_data", resData, 4'b1110);
      checkOutput("sub_hold_flags", resFlags, 3'b010);
      checkOutput("sub_hold_alu_a", aluA, 4'd3);
      checkOutput("sub_hold_count", opCount, 1);
    end
    handshake();
    checkOutput("sub_op_count", opCount, 2);
    checkOutput("sub_sticky", stickyCv, 2'b01);

    // Shift: B=3 shifted by A=2 -> 1100, no carry, sticky unchanged
    applyStimulus(OP_LSL, 4'd2, 4'd3, 4'b1100, 3'b000);
    waitResult(2);
    handshake();
    checkOutput("shift_op_count", opCount, 3);
    checkOutput("shift_sticky", stickyCv, 2'b01);
    checkOutput("shift_alu_opcode_kept", aluOpcode, OP_LSL);
    checkOutput("shift_alu_b_kept", aluB, 4'd3);

    // Abort after A accepted; abort also blocks a simultaneous B nibble
    inData  = OP_AND;
    inValid = 1'b1;
    tick();
    inData = 4'd1;
    tick();
    inData  = 4'd7;
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    inValid = 1'b0;
    checkOutput("abort_in_ready", inReady, 1);
    checkOutput("abort_res_valid", resValid, 0);
    checkOutput("abort_alu_b_blocked", aluB, 4'd3);
    applyStimulus(OP_XOR, 4'd5, 4'd12, 4'b1001, 3'b000);
    waitResult(2);
    handshake();
    checkOutput("abort_op_count", opCount, 4);

    // Abort coincident with result handshake
    applyStimulus(OP_ADD, 4'd7, 4'd9, 4'd0, 3'b011);
    waitResult(2);
    resReady = 1'b1;
    abortIn  = 1'b1;
    tick();
    resReady = 1'b0;
    abortIn  = 1'b0;
    checkOutput("abort_hs_res_valid", resValid, 0);
    checkOutput("abort_hs_op_count", opCount, 4);
    checkOutput("abort_hs_sticky", stickyCv, 2'b01);
    checkOutput("abort_hs_in_ready", inReady, 1);

    // Clear coincident with handshake: clear wins
    applyStimulus(OP_SUB, 4'd3, 4'd5, 4'b1110, 3'b010);
    waitResult(2);
    clrSticky = 1'b1;
    handshake();
    clrSticky = 1'b0;
    checkOutput("clr_hs_sticky", stickyCv, 2'b00);
    checkOutput("clr_hs_op_count", opCount, 5);

    // Run the counter up to 255 with random XOR operations
    for (int i = 0; i < 250; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      applyStimulus(OP_XOR, a, b, a ^ b, {2'b00, ((a ^ b) == 4'd0)});
      waitResult(2);
      handshake();
    end
    checkOutput("count_at_255", opCount, 255);
    checkOutput("xor_sticky", stickyCv, 2'b00);

    // 7+1 overflows signed: V=1, C=0; counter wraps to 0
    applyStimulus(OP_ADD, 4'd7, 4'd1, 4'b1000, 3'b100);
    waitResult(2);
    handshake();
    checkOutput("wrap_op_count", opCount, 0);
    checkOutput("wrap_sticky", stickyCv, 2'b10);

    applyStimulus(OP_ADD, 4'd7, 4'd9, 4'd0, 3'b011);
    waitResult(2);
    handshake();
    checkOutput("post_wrap_op_count", opCount, 1);
    checkOutput("post_wrap_sticky", stickyCv, 2'b11);

    // Reset while in S_EXEC
    applyStimulus(OP_SUB, 4'd3, 4'd5, 4'b1110, 3'b010);
    expQ.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", inReady, 1);
    checkOutput("mid_rst_res_valid", resValid, 0);
    checkOutput("mid_rst_op_count", opCount, 0);
    checkOutput("mid_rst_sticky", stickyCv, 0);
    checkOutput("mid_rst_alu_opcode", aluOpcode, 0);
    checkOutput("mid_rst_alu_a", aluA, 0);
    checkOutput("mid_rst_alu_b", aluB, 0);
    checkOutput("mid_rst_res_data", resData, 0);
    checkOutput("mid_rst_res_flags", resFlags, 0);
    tick();
    checkOutput("mid_rst_res_valid_later", resValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
